octave_step_ctrl: RTL

//  Front-end sequencer for the octave up/down FSM. Turns raw octave buttons into

---
 rtl/octave_step_ctrl_pkg.sv | 17 +
 rtl/octave_step_ctrl_button.sv | 91 +++++++++
 rtl/octave_step_ctrl.sv | 70 +++++++
 3 files changed

// File: rtl/octave_step_ctrl_pkg.sv
// synth_ctrl_pkg: shared types and helpers for the octave step sequencer
//  btn_state_t : per-button debounce/repeat FSM states
//  step_dir_t  : direction stored in the deferred-step slot
//  max3        : largest of three values, used to size the shared counter
package synth_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_REL} btn_state_t;

    typedef enum logic {DIR_UP, DIR_DN} step_dir_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/octave_step_ctrl_button.sv
// octave_button: synchroniser plus debounce/auto-repeat FSM for one octave button
//  clk   in   system clock
//  n_rst in   asynchronous, active-low reset
//  raw   in   raw asynchronous button level, active-high
//  evt   out  registered 1-cycle event: accepted press or auto-repeat
module octave_button
    import synth_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 200000,
    parameter int REPEAT_CYCLES   = 100000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw,
    output logic evt
);

    localparam int CW = $clog2(max3(HOLD_CYCLES, REPEAT_CYCLES, DEBOUNCE_CYCLES) + 1);
    // Terminal counts are one short because the sample that completes a
    // period is the one evaluated against them; evt is registered on it.
    localparam logic [CW-1:0] DB_END   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_END  = CW'(REPEAT_CYCLES - 1);

    logic            s1, s2, rep;
    logic [CW-1:0]   cnt;
    btn_state_t      st;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            st  <= IDLE;
            cnt <= '0;
            rep <= 1'b0;
            evt <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            evt <= 1'b0;
            case (st)
                IDLE: if (s2) begin
                    st  <= DB_PRESS;
                    cnt <= CW'(1);
                end
                DB_PRESS: if (!s2) begin
                    st  <= IDLE;
                    cnt <= '0;
                end else if (cnt == DB_END) begin
                    evt <= 1'b1;
                    st  <= HELD;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
                HELD: if (!s2) begin
                    st  <= DB_REL;
                    rep <= 1'b0;
                    cnt <= CW'(1);
                end else if (REPEAT_EN) begin
                    if (cnt == HOLD_END) begin
                        evt <= 1'b1;
                        st  <= REPEAT;
                        cnt <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                REPEAT: if (!s2) begin
                    st  <= DB_REL;
                    rep <= 1'b1;
                    cnt <= CW'(1);
                end else if (cnt == REP_END) begin
                    evt <= 1'b1;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
                // A bounce during release resumes the held phase with a fresh timer.
                DB_REL: if (s2) begin
                    st  <= rep ? REPEAT : HELD;
                    cnt <= '0;
                end else if (cnt == DB_END) begin
                    st  <= IDLE;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
                default: begin
                    st  <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/octave_step_ctrl.sv
// octave_step_ctrl: turns octave buttons into clean step pulses, deferring steps while a note sounds
//  clk             in   system clock
//  n_rst           in   asynchronous, active-low reset
//  btn_up_raw      in   raw octave-up button
//  btn_dn_raw      in   raw octave-down button
//  note_active     in   a note is sounding; steps are held back until it drops
//  enable          in   0 discards events and clears the deferred step
//  octave_key_up   out  1-cycle step-up pulse
//  octave_key_down out  1-cycle step-down pulse
//  step_pending    out  a deferred step is waiting for note release
module octave_step_ctrl
    import synth_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 200000,
    parameter int REPEAT_CYCLES   = 100000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_up_raw,
    input  logic btn_dn_raw,
    input  logic note_active,
    input  logic enable,
    output logic octave_key_up,
    output logic octave_key_down,
    output logic step_pending
);

    logic      evt_up, evt_dn;
    step_dir_t pdir;

    octave_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(REPEAT_EN)
    ) u_up (.clk(clk), .n_rst(n_rst), .raw(btn_up_raw), .evt(evt_up));

    octave_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(REPEAT_EN)
    ) u_dn (.clk(clk), .n_rst(n_rst), .raw(btn_dn_raw), .evt(evt_dn));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            octave_key_up   <= 1'b0;
            octave_key_down <= 1'b0;
            step_pending    <= 1'b0;
            pdir            <= DIR_UP;
        end else begin
            octave_key_up   <= 1'b0;
            octave_key_down <= 1'b0;
            // Simultaneous up and down is ambiguous: ignore it and leave the slot alone.
            if (!(evt_up && evt_dn)) begin
                if (!enable) step_pending <= 1'b0;
                else if (note_active) begin
                    if (evt_up || evt_dn) begin
                        step_pending <= 1'b1;
                        pdir         <= evt_up ? DIR_UP : DIR_DN;
                    end
                end else if (evt_up || evt_dn || step_pending) begin
                    // A fresh event supersedes the stored one; only one pulse issues.
                    octave_key_up   <= evt_up || (!evt_dn && pdir == DIR_UP);
                    octave_key_down <= evt_dn || (!evt_up && pdir == DIR_DN);
                    step_pending    <= 1'b0;
                end
            end
        end
    end

endmodule
